// File: rtl/dm_mem_arbiter_pkg.sv
// Shared types and constants for the debug-memory arbiter slice.
package dm_mem_arbiter_pkg;

  // Requester identifiers; also the encoding of the response-stage owner bit.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int unsigned DM_ADDR_BITS = 12;

  // Response-stage record layout {valid, owner, err}.
  localparam int unsigned STG_ERR   = 0;
  localparam int unsigned STG_OWNER = 1;
  localparam int unsigned STG_VALID = 2;
  localparam int unsigned STG_W     = 3;

endpackage

// File: rtl/dm_mem_arbiter_if.sv
// Bus bundle for the arbiter: fetch port, data port and the dm_mem slave port.
interface dm_mem_arbiter_if #(
  parameter int unsigned BusWidth = 32
);
  logic                    if_req_i;
  logic [BusWidth-1:0]     if_addr_i;
  logic                    if_gnt_o;
  logic                    if_rvalid_o;
  logic [BusWidth-1:0]     if_rdata_o;
  logic                    if_err_o;

  logic                    d_req_i;
  logic                    d_we_i;
  logic [BusWidth-1:0]     d_addr_i;
  logic [BusWidth-1:0]     d_wdata_i;
  logic [BusWidth/8-1:0]   d_be_i;
  logic                    d_gnt_o;
  logic                    d_rvalid_o;
  logic [BusWidth-1:0]     d_rdata_o;
  logic                    d_err_o;

  logic                    req_o;
  logic                    we_o;
  logic [BusWidth-1:0]     addr_o;
  logic [BusWidth-1:0]     wdata_o;
  logic [BusWidth/8-1:0]   be_o;
  logic [BusWidth-1:0]     rdata_i;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output req_o, we_o, addr_o, wdata_o, be_o
  );

  // Environment side: core requesters plus dm_mem.
  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  req_o, we_o, addr_o, wdata_o, be_o
  );
endinterface

// File: rtl/dm_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational in the request cycle.
module dm_rr_arb2
  import dm_mem_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,   // [0] fetch, [1] data
  output logic [1:0] gnt_o
);

  // Requester that wins the next conflict; the opposite of the last grant.
  req_id_e prio_q, prio_d;

  // Priority register, fetch favoured out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= REQ_IF;
    else         prio_q <= prio_d;
  end

  // Hand priority to the other requester only when a grant happens.
  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0])      prio_d = REQ_D;
    else if (gnt_o[1]) prio_d = REQ_IF;
  end

  // Grant a lone requester directly; resolve conflicts by priority.
  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (prio_q == REQ_IF) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_mem_arbiter.sv
// Shares the dm_mem slave port between the fetch and data ports, decodes the
// debug window and returns in-order responses after a fixed latency.
module dm_mem_arbiter
  import dm_mem_arbiter_pkg::*;
#(
  parameter int unsigned         BusWidth      = 32,
  parameter logic [BusWidth-1:0] DmBaseAddress = '0,
  parameter int unsigned         DmAddrBits    = DM_ADDR_BITS,
  parameter int unsigned         RspLatency    = 1
) (
  input logic            clk_i,
  input logic            rst_ni,
  dm_mem_arbiter_if.slave bus
);

  logic [1:0]          req_vec;
  logic [1:0]          gnt;
  logic                win_d;
  logic                any_gnt;
  logic                in_win;
  logic [BusWidth-1:0] win_addr;
  logic [STG_W-1:0]    stg_in;
  logic [STG_W-1:0]    stg_q [RspLatency];
  logic [STG_W-1:0]    stg_last;

  // Requests are masked while reset is asserted so no grant leaks out.
  assign req_vec = {bus.d_req_i, bus.if_req_i} & {2{rst_ni}};

  dm_rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (req_vec),
    .gnt_o (gnt)
  );

  assign win_d         = gnt[1];
  assign any_gnt       = |gnt;
  assign win_addr      = win_d ? bus.d_addr_i : bus.if_addr_i;
  assign in_win        = (win_addr[BusWidth-1:DmAddrBits] ==
                          DmBaseAddress[BusWidth-1:DmAddrBits]);
  assign bus.if_gnt_o  = gnt[0];
  assign bus.d_gnt_o   = gnt[1];

  // Drive dm_mem only for an in-window grant; fetch never writes.
  always_comb begin
    bus.req_o   = 1'b0;
    bus.we_o    = 1'b0;
    bus.addr_o  = '0;
    bus.wdata_o = '0;
    bus.be_o    = '0;
    if (any_gnt && in_win) begin
      bus.req_o  = 1'b1;
      bus.addr_o = win_addr;
      if (win_d) begin
        bus.we_o    = bus.d_we_i;
        bus.wdata_o = bus.d_wdata_i;
        bus.be_o    = bus.d_be_i;
      end
    end
  end

  // Record for the response pipeline; out-of-window grants carry err.
  always_comb begin
    stg_in = '0;
    if (any_gnt) begin
      stg_in[STG_VALID] = 1'b1;
      stg_in[STG_OWNER] = win_d;
      stg_in[STG_ERR]   = ~in_win;
    end
  end

  // Response shift register; reset discards anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RspLatency; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= stg_in;
      for (int unsigned i = 1; i < RspLatency; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign stg_last = stg_q[RspLatency-1];

  // Route the last stage to its owner; error responses return zero data.
  always_comb begin
    bus.if_rvalid_o = 1'b0;
    bus.if_rdata_o  = '0;
    bus.if_err_o    = 1'b0;
    bus.d_rvalid_o  = 1'b0;
    bus.d_rdata_o   = '0;
    bus.d_err_o     = 1'b0;
    if (stg_last[STG_VALID]) begin
      if (stg_last[STG_OWNER] == REQ_D) begin
        bus.d_rvalid_o = 1'b1;
        bus.d_err_o    = stg_last[STG_ERR];
        bus.d_rdata_o  = stg_last[STG_ERR] ? '0 : bus.rdata_i;
      end else begin
        bus.if_rvalid_o = 1'b1;
        bus.if_err_o    = stg_last[STG_ERR];
        bus.if_rdata_o  = stg_last[STG_ERR] ? '0 : bus.rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Self-checking bench for dm_mem_arbiter (latency 1 and latency 2 instances).
module tb_dm_mem_arbiter;
  import dm_mem_arbiter_pkg::*;

  localparam int unsigned BW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_mem_arbiter_if #(.BusWidth(BW)) b1 ();
  dm_mem_arbiter_if #(.BusWidth(BW)) b2 ();

  dm_mem_arbiter #(.BusWidth(BW), .RspLatency(1)) u_dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b1)
  );

  dm_mem_arbiter #(.BusWidth(BW), .RspLatency(2)) u_dut2 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b2)
  );

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [31:0] m1, m2a, m2b;
  always @(posedge clk) begin
    m1  <= b1.addr_o;
    m2a <= b2.addr_o;
    m2b <= m2a;
  end
  assign b1.rdata_i = mem_f(m1);
  assign b2.rdata_i = mem_f(m2b);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          dut;
    logic        port;
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic push(input int d, input logic p, input logic [31:0] rd,
                      input logic e, input logic cd, input int lat);
    exp_t x;
    x.dut = d; x.port = p; x.rdata = rd; x.err = e; x.chk_data = cd; x.due = cyc + lat;
    sb.push_back(x);
  endtask

  task automatic take(input int d, input logic p, input logic [31:0] rd, input logic e);
    int idx;
    idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].dut == d) idx = k;
    check($sformatf("rsp_expected_dut%0d", d), (idx >= 0), 1'b1);
    if (idx >= 0) begin
      check($sformatf("rsp_cycle_dut%0d", d), cyc, sb[idx].due);
      check($sformatf("rsp_port_dut%0d", d), p, sb[idx].port);
      check($sformatf("rsp_err_dut%0d", d), e, sb[idx].err);
      if (sb[idx].chk_data) check($sformatf("rsp_rdata_dut%0d", d), rd, sb[idx].rdata);
      sb.delete(idx);
    end
  endtask

  task automatic mon_dut(input int d,
                         input logic iv, input logic [31:0] ird, input logic ie,
                         input logic dv, input logic [31:0] drd, input logic de);
    int k;
    check($sformatf("rsp_one_port_dut%0d", d), (iv && dv), 1'b0);
    if (iv) take(d, REQ_IF, ird, ie);
    if (dv) take(d, REQ_D, drd, de);
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].dut == d && sb[k].due < cyc) begin
        check($sformatf("rsp_missing_dut%0d", d), cyc, sb[k].due);
        sb.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      mon_dut(0, b1.if_rvalid_o, b1.if_rdata_o, b1.if_err_o, b1.d_rvalid_o, b1.d_rdata_o, b1.d_err_o);
      mon_dut(1, b2.if_rvalid_o, b2.if_rdata_o, b2.if_err_o, b2.d_rvalid_o, b2.d_rdata_o, b2.d_err_o);
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vt[13];

  task automatic idle_inputs();
    b1.if_req_i = 0; b1.if_addr_i = '0; b1.d_req_i = 0; b1.d_we_i = 0;
    b1.d_addr_i = '0; b1.d_wdata_i = '0; b1.d_be_i = '0;
    b2.if_req_i = 0; b2.if_addr_i = '0; b2.d_req_i = 0; b2.d_we_i = 0;
    b2.d_addr_i = '0; b2.d_wdata_i = '0; b2.d_be_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             if_req if_addr        d_req we d_addr          d_wdata        be    gI gD rq we e_addr        e_wdata        e_be
    vt[0]  = '{1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0,          4'h0};
    vt[1]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001, 4'hF};
    vt[2]  = '{1'b1, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0380, 32'h0,          4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0,          4'h0};
    vt[3]  = '{1'b1, 32'h0000_0800, 1'b1, 1'b0, 32'h0000_0380, 32'h0,          4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0380, 32'h0,          4'hF};
    vt[4]  = vt[2];
    vt[5]  = vt[3];
    vt[6]  = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h1000_0000, 32'h0,          4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0};
    vt[7]  = '{1'b0, 32'h0,          1'b0, 1'b0, 32'h0,          32'h0,          4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0};
    vt[8]  = '{1'b1, 32'hFFFF_F000, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0};
    vt[9]  = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0000_1000, 32'h0,          4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0};
    vt[10] = '{1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 32'h0,          32'h0,          4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          4'h0};
    vt[11] = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3};
    vt[12] = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,          4'h0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_dut1_outputs",
          {b1.if_gnt_o, b1.if_rvalid_o, b1.if_err_o, b1.d_gnt_o, b1.d_rvalid_o, b1.d_err_o,
           b1.req_o, b1.we_o, b1.be_o}, '0);
    check("reset_dut1_addr", b1.addr_o, '0);
    check("reset_dut1_rdata", b1.if_rdata_o | b1.d_rdata_o | b1.wdata_o, '0);
    check("reset_dut2_outputs",
          {b2.if_gnt_o, b2.if_rvalid_o, b2.d_gnt_o, b2.d_rvalid_o, b2.req_o, b2.we_o}, '0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table-driven vectors on the latency-1 instance.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      b1.if_req_i  = vt[i].if_req;
      b1.if_addr_i = vt[i].if_addr;
      b1.d_req_i   = vt[i].d_req;
      b1.d_we_i    = vt[i].d_we;
      b1.d_addr_i  = vt[i].d_addr;
      b1.d_wdata_i = vt[i].d_wdata;
      b1.d_be_i    = vt[i].d_be;
      #1;
      check($sformatf("v%0d_if_gnt", i), b1.if_gnt_o, vt[i].e_if_gnt);
      check($sformatf("v%0d_d_gnt", i),  b1.d_gnt_o,  vt[i].e_d_gnt);
      check($sformatf("v%0d_req_o", i),  b1.req_o,    vt[i].e_req);
      check($sformatf("v%0d_we_o", i),   b1.we_o,     vt[i].e_we);
      check($sformatf("v%0d_addr_o", i), b1.addr_o,   vt[i].e_addr);
      check($sformatf("v%0d_wdata_o", i), b1.wdata_o, vt[i].e_wdata);
      check($sformatf("v%0d_be_o", i),   b1.be_o,     vt[i].e_be);
      if (vt[i].e_if_gnt)
        push(0, REQ_IF, vt[i].e_req ? mem_f(vt[i].if_addr) : 32'h0, ~vt[i].e_req, 1'b1, 1);
      if (vt[i].e_d_gnt)
        push(0, REQ_D, vt[i].e_req ? mem_f(vt[i].d_addr) : 32'h0, ~vt[i].e_req,
             ~(vt[i].d_we & vt[i].e_req), 1);
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    // Latency 2: back-to-back data reads return in order at t+2, t+3.
    @(negedge clk);
    b2.d_req_i = 1; b2.d_addr_i = 32'h0000_0380; b2.d_be_i = 4'hF;
    #1;
    check("lat2_gnt0", b2.d_gnt_o, 1'b1);
    check("lat2_req0", b2.req_o, 1'b1);
    push(1, REQ_D, mem_f(32'h0000_0380), 1'b0, 1'b1, 2);
    @(negedge clk);
    b2.d_addr_i = 32'h0000_0384;
    #1;
    check("lat2_gnt1", b2.d_gnt_o, 1'b1);
    check("lat2_no_early_rsp", b2.d_rvalid_o, 1'b0);
    push(1, REQ_D, mem_f(32'h0000_0384), 1'b0, 1'b1, 2);
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);

    // Reset right after a grant: the in-flight responses must vanish.
    @(negedge clk);
    b1.if_req_i = 1; b1.if_addr_i = 32'h0000_0800;
    b2.d_req_i  = 1; b2.d_addr_i  = 32'h0000_0380; b2.d_be_i = 4'hF;
    #1;
    check("rst_pre_if_gnt", b1.if_gnt_o, 1'b1);
    check("rst_pre_d_gnt2", b2.d_gnt_o, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_no_rvalid_dut1", {b1.if_rvalid_o, b1.d_rvalid_o}, 2'b00);
      check("rst_no_rvalid_dut2", {b2.if_rvalid_o, b2.d_rvalid_o}, 2'b00);
    end
    rst_n = 1'b1;
    // Pointer back to fetch: a conflict now favours fetch.
    @(negedge clk);
    b1.if_req_i = 1; b1.if_addr_i = 32'h0000_0010;
    b1.d_req_i  = 1; b1.d_addr_i  = 32'h0000_0020; b1.d_be_i = 4'hF;
    #1;
    check("post_rst_if_gnt", b1.if_gnt_o, 1'b1);
    check("post_rst_d_gnt", b1.d_gnt_o, 1'b0);
    check("post_rst_addr", b1.addr_o, 32'h0000_0010);
    push(0, REQ_IF, mem_f(32'h0000_0010), 1'b0, 1'b1, 1);
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
